// File: rtl/booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : booth_dot_accumulator
// Description : Saturating signed dot-product accumulator fed by a Booth
//               multiplier, with a valid/ready result register.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_dot_accumulator #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic signed [7:0]       prod_in,
    input  logic                    prod_valid,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    sum_sat,
    output logic                    overrun,
    output logic                    busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [LEN_W:0] c_full_len = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] c_one      = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W:0]   r_cnt;
    logic             r_vsat;
    logic [ACC_W-1:0] r_sum_out;
    logic             r_sum_valid;
    logic             r_sum_sat;
    logic             r_overrun;

    logic             w_idle;
    logic [LEN_W:0]   w_len;
    logic [LEN_W:0]   w_cnt_next;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_base;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_vsat_next;
    logic             w_done;
    logic             w_slot_free;

    assign w_idle      = (r_state == S_IDLE);
    assign w_len       = (vec_len == '0) ? c_full_len : {1'b0, vec_len};
    assign w_cnt_next  = (w_idle ? w_len : r_cnt) - c_one;
    assign w_prod_ext  = {{(ACC_W-7){prod_in[7]}}, prod_in};
    // A new vector starts from zero, so the first product can never clamp.
    assign w_base      = w_idle ? '0 : {r_acc[ACC_W-1], r_acc};
    assign w_sum       = w_base + w_prod_ext;
    assign w_ovf       = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_acc_next  = !w_ovf ? w_sum[ACC_W-1:0]
                                : (w_sum[ACC_W] ? c_acc_min : c_acc_max);
    assign w_vsat_next = (!w_idle && r_vsat) || w_ovf;
    assign w_done      = prod_valid && (w_cnt_next == '0);
    assign w_slot_free = !r_sum_valid || sum_ready;

    always_comb begin
        w_state_next = r_state;
        if (prod_valid) begin
            w_state_next = w_done ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_vsat      <= 1'b0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_sum_sat   <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            // The held sum_out is left in place; only its valid is dropped.
            r_acc       <= '0;
            r_cnt       <= '0;
            r_vsat      <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum_sat   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (prod_valid) begin
                r_acc  <= w_acc_next;
                r_cnt  <= w_cnt_next;
                r_vsat <= w_vsat_next;
            end
            if (w_done) begin
                if (w_slot_free) begin
                    r_sum_out   <= w_acc_next;
                    r_sum_sat   <= w_vsat_next;
                    r_sum_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (r_sum_valid && sum_ready) begin
                r_sum_valid <= 1'b0;
            end
        end
    end

    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign sum_sat   = r_sum_sat;
    assign overrun   = r_overrun;
    assign busy      = (r_state == S_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_dot_accumulator
// Description : Self-checking bench for booth_dot_accumulator (ACC_W 12 and 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_dot_accumulator;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic [7:0]       prod_in = '0;
    logic             prod_valid = 1'b0;
    logic             sum_ready = 1'b0;

    logic signed [11:0] so12;
    logic               sv12, ss12, ov12, bz12;
    logic signed [9:0]  so10;
    logic               sv10, ss10, ov10, bz10;

    booth_dot_accumulator #(.ACC_W(12), .LEN_W(LEN_W)) u12 (
        .clk(clk), .reset(reset), .clear(clear), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .sum_out(so12),
        .sum_valid(sv12), .sum_ready(sum_ready), .sum_sat(ss12),
        .overrun(ov12), .busy(bz12)
    );

    booth_dot_accumulator #(.ACC_W(10), .LEN_W(LEN_W)) u10 (
        .clk(clk), .reset(reset), .clear(clear), .vec_len(vec_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .sum_out(so10),
        .sum_valid(sv10), .sum_ready(sum_ready), .sum_sat(ss10),
        .overrun(ov10), .busy(bz10)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: one slot per DUT instance (0: ACC_W=12, 1: ACC_W=10)
    int width [2] = '{12, 10};
    int m_acc [2];
    int m_left[2];
    int m_out [2];
    bit m_busy[2], m_vsat[2], m_valid[2], m_sat[2], m_ovr[2], m_known[2];

    typedef struct {
        bit       rn;
        bit       clr;
        bit [3:0] len;
        int       prod;
        bit       pv;
        bit       rdy;
        int       e_out;
        bit       c_out;
        bit       e_valid;
        bit       e_sat;
        bit       e_ovr;
        bit       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int act_out(int d);
        return (d == 0) ? int'(so12) : int'(so10);
    endfunction

    function automatic bit [3:0] act_flags(int d);
        return (d == 0) ? {sv12, ss12, ov12, bz12} : {sv10, ss10, ov10, bz10};
    endfunction

    task automatic model_edge(int d);
        int  mx = (1 << (width[d] - 1)) - 1;
        int  mn = -(1 << (width[d] - 1));
        int  p  = int'($signed(prod_in));
        bit  drain;
        bit  done = 1'b0;
        if (!reset) begin
            m_acc[d] = 0; m_left[d] = 0; m_out[d] = 0;
            m_busy[d] = 0; m_vsat[d] = 0; m_valid[d] = 0; m_sat[d] = 0;
            m_ovr[d] = 0; m_known[d] = 1;
        end else if (clear) begin
            m_acc[d] = 0; m_left[d] = 0;
            m_busy[d] = 0; m_vsat[d] = 0; m_valid[d] = 0; m_sat[d] = 0;
            m_ovr[d] = 0; m_known[d] = 0;
        end else begin
            drain = m_valid[d] && sum_ready;
            if (prod_valid) begin
                if (!m_busy[d]) begin
                    m_left[d] = (vec_len == 0) ? (1 << LEN_W) : int'(vec_len);
                    m_acc[d]  = p;
                    m_vsat[d] = 0;
                end else begin
                    int s = m_acc[d] + p;
                    if (s > mx) begin s = mx; m_vsat[d] = 1; end
                    else if (s < mn) begin s = mn; m_vsat[d] = 1; end
                    m_acc[d] = s;
                end
                m_left[d]--;
                done      = (m_left[d] == 0);
                m_busy[d] = !done;
            end
            if (done) begin
                if (!m_valid[d] || drain) begin
                    m_out[d] = m_acc[d]; m_sat[d] = m_vsat[d];
                    m_valid[d] = 1; m_known[d] = 1;
                end else begin
                    m_ovr[d] = 1;
                end
            end else if (drain) begin
                m_valid[d] = 0;
            end
        end
    endtask

    task automatic model_check(int d);
        bit [3:0] f = act_flags(d);
        string    s = (d == 0) ? "w12" : "w10";
        chk({"model_valid_", s}, int'(f[3]), int'(m_valid[d]));
        chk({"model_sat_", s},   int'(f[2]), int'(m_sat[d]));
        chk({"model_ovr_", s},   int'(f[1]), int'(m_ovr[d]));
        chk({"model_busy_", s},  int'(f[0]), int'(m_busy[d]));
        if (m_known[d]) chk({"model_out_", s}, act_out(d), m_out[d]);
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic step(bit rn, bit clr, bit [3:0] len, int prod, bit pv, bit rdy);
        reset = rn; clear = clr; vec_len = len; prod_in = 8'(prod);
        prod_valid = pv; sum_ready = rdy;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        model_check(0);
        model_check(1);
    endtask

    function automatic void add(bit rn, bit clr, bit [3:0] len, int prod, bit pv, bit rdy,
                                int eo, bit co, bit ev, bit es, bit eov, bit eb);
        vec_t v;
        v.rn = rn; v.clr = clr; v.len = len; v.prod = prod; v.pv = pv; v.rdy = rdy;
        v.e_out = eo; v.c_out = co; v.e_valid = ev; v.e_sat = es; v.e_ovr = eov; v.e_busy = eb;
        tbl.push_back(v);
    endfunction

    initial begin
        // reset
        add(0,0,0,   0,0,0,     0,1,0,0,0,0);
        // basic length-3 vector, non-consecutive pulses
        add(1,0,3,   6,1,1,     0,0,0,0,0,1);
        add(1,0,3,   0,0,1,     0,0,0,0,0,1);
        add(1,0,3, -12,1,1,     0,0,0,0,0,1);
        add(1,0,3,   0,0,1,     0,0,0,0,0,1);
        add(1,0,3,  49,1,1,    43,1,1,0,0,0);
        add(1,0,3,   0,0,1,     0,0,0,0,0,0);
        // vec_len=0 means 16 products, back-to-back minimum
        for (int i = 0; i < 16; i++)
            add(1,0,0,-128,1,1, (i == 15) ? -2048 : 0, i == 15, i == 15, 0, 0, i < 15);
        add(1,0,1, 127,1,1,   127,1,1,0,0,0);
        add(1,0,1,   0,0,1,     0,0,0,0,0,0);
        // back-pressure and overrun
        add(1,0,2,  10,1,0,     0,0,0,0,0,1);
        add(1,0,2,  20,1,0,    30,1,1,0,0,0);
        add(1,0,2,   1,1,0,    30,1,1,0,0,1);
        add(1,0,2,   1,1,0,    30,1,1,0,1,0);
        add(1,0,2,   0,0,0,    30,1,1,0,1,0);
        // drain and completion in the same cycle
        add(1,0,1,  -5,1,1,    -5,1,1,0,1,0);
        add(1,0,1,   0,0,1,     0,0,0,0,1,0);
        // reset mid-vector
        add(1,0,4,  50,1,1,     0,0,0,0,1,1);
        add(1,0,4,  50,1,1,     0,0,0,0,1,1);
        add(0,0,4,   0,0,1,     0,1,0,0,0,0);
        add(1,0,2,   7,1,1,     0,0,0,0,0,1);
        add(1,0,2,   8,1,1,    15,1,1,0,0,0);
        add(1,0,2,   0,0,1,     0,0,0,0,0,0);
        // clear mid-vector, coincident with a product
        add(1,0,1,   1,1,0,     1,1,1,0,0,0);
        add(1,0,1,   2,1,0,     1,1,1,0,1,0);
        add(1,0,4,  50,1,0,     1,1,1,0,1,1);
        add(1,1,4,  50,1,0,     0,0,0,0,0,0);
        add(1,0,2,   7,1,1,     0,0,0,0,0,1);
        add(1,0,2,   8,1,1,    15,1,1,0,0,0);
        add(1,0,2,   0,0,1,     0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rn, tbl[i].clr, tbl[i].len, tbl[i].prod, tbl[i].pv, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), int'(sv12), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_sat", i),   int'(ss12), int'(tbl[i].e_sat));
            chk($sformatf("tbl%0d_ovr", i),   int'(ov12), int'(tbl[i].e_ovr));
            chk($sformatf("tbl%0d_busy", i),  int'(bz12), int'(tbl[i].e_busy));
            if (tbl[i].c_out) chk($sformatf("tbl%0d_out", i), int'(so12), tbl[i].e_out);
        end

        // saturation on the narrow instance, then a clean vector
        step(0,0,0,0,0,1);
        for (int i = 0; i < 5; i++) step(1,0,5,127,1,1);
        chk("sat10_out", int'(so10), 511);
        chk("sat10_flag", int'(ss10), 1);
        chk("sat10_valid", int'(sv10), 1);
        step(1,0,2,3,1,1);
        step(1,0,2,4,1,1);
        chk("post_sat10_out", int'(so10), 7);
        chk("post_sat10_flag", int'(ss10), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 149) == 0),
                 4'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_dot_accumulator.md
Name: booth_dot_accumulator

Overview:
- Downstream consumer of the 4x4 signed Booth multiplier.
- Captures each 8-bit signed product on the multiplier's one-cycle valid pulse and accumulates a programmable-length vector of products into a saturating signed sum (dot product).
- Presents each completed sum on a valid/ready output register.
- Accumulation of the next vector continues while a previous result is held; the multiplier has no back-pressure, so products are never stalled.

Parameters:
- ACC_W, 12, accumulator/result width in bits (signed, two's complement); must be at least 9.
- LEN_W, 4, width of vec_len; maximum vector length is 2^LEN_W.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- clear  input  1  synchronous soft clear, active-high.
- vec_len  input  LEN_W  products per vector; 0 encodes 2^LEN_W.
- prod_in  input  8  signed product from multiplier.
- prod_valid  input  1  one-cycle pulse, prod_in valid.
- sum_out  output  ACC_W  signed completed dot product.
- sum_valid  output  1  sum_out holds an unconsumed result.
- sum_ready  input  1  consumer accepts sum_out when sum_valid=1.
- sum_sat  output  1  saturation occurred during the vector in sum_out.
- overrun  output  1  sticky: a completed result was dropped.
- busy  output  1  a vector is partially accumulated.

Behaviour:
- Reset (reset=0 at a rising edge) sets all outputs and internal state to zero: sum_out=0, sum_valid=0, sum_sat=0, overrun=0, busy=0, accumulator=0, remaining count=0, FSM=IDLE.
- clear=1 has the same effect as reset, except sum_out is not required to be zeroed. clear takes priority over prod_valid in the same cycle; that product is discarded.
- Accumulator FSM, IDLE:
  - On prod_valid, sample vec_len into the remaining count (0 maps to 2^LEN_W).
  - Load acc = sext(prod_in) and set the vector saturation flag to 0.
  - If length=1, the vector completes this cycle; otherwise go to ACCUM with busy=1.
- Accumulator FSM, ACCUM:
  - Each prod_valid: acc = sat(acc + sext(prod_in)) and decrement the remaining count.
  - When the count reaches 0, the vector completes and the FSM returns to IDLE with busy=0.
  - vec_len is ignored mid-vector.
- Arithmetic:
  - Add in ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that maximum; if it is below -2^(ACC_W-1), clamp to that minimum.
  - Any clamp sets the vector saturation flag, which stays set until the vector completes.
- Completion, where the product arrives in cycle N:
  - If the output slot is free (sum_valid=0) or is emptying in cycle N (sum_valid && sum_ready), then at N+1: sum_out = final acc, sum_sat = vector flag, sum_valid=1.
  - Latency is one cycle from the last prod_valid to sum_valid.
  - Otherwise the result is dropped, overrun is set to 1 (held until reset/clear), and the held sum_out, sum_valid and sum_sat are unchanged.
- Output handshake:
  - sum_valid && sum_ready at an edge consumes the result; sum_valid falls at the next edge unless a completion reloads it in the same cycle.
  - sum_out and sum_sat are stable while sum_valid=1 and sum_ready=0.
  - sum_ready is ignored while sum_valid=0.
- Back-to-back products (prod_valid every cycle) are supported without loss.
- Reset or clear mid-vector discards the partial sum. The next prod_valid starts a new vector.

Test Plan:
- Basic: vec_len=3; products 6, -12, 49 on non-consecutive pulses; sum_ready=1 -> one cycle after the third pulse, sum_out=43, sum_valid=1 for one cycle, sum_sat=0, busy high between the first and third products.
- Length encoding and minimum boundary: vec_len=0 (16 products); 16 products of -128 back-to-back -> sum_out=-2048 (0x800), sum_sat=0. Then vec_len=1 with product 127 -> sum_out=127 one cycle later, busy never asserted.
- Saturation: ACC_W=10, vec_len=5, five products of 127 -> sum_out=511, sum_sat=1. A following vector of length 2 with products 3, 4 -> sum_out=7, sum_sat=0.
- Back-pressure and overrun:
  - sum_ready=0; vector A (len 2: 10, 20) completes -> sum_out=30 is held.
  - Vector B (len 2: 1, 1) completes -> dropped, overrun=1, sum_out remains 30.
  - Raise sum_ready -> 30 is consumed and sum_valid falls.
- Simultaneous drain and completion: sum_valid=1 holding 30 with sum_ready=1 in the same cycle as the last product of vector C (len 1: -5) -> next cycle sum_out=-5, sum_valid=1, overrun unchanged.
- Reset and clear mid-vector:
  - vec_len=4; after 2 products (50, 50), pulse reset=0 for one cycle -> all outputs 0.
  - A fresh vector with vec_len=2 (7, 8) -> sum_out=15.
  - Repeat with clear=1 coincident with a prod_valid -> that product is discarded and overrun returns to 0.
